// File: rtl/uart_sys_ctrl.sv
// uart_sys_ctrl
//   Command sequencer sitting between the UART RX/TX state machines and the
//   register file. It is the sole master of the register-file port.
//
//   Frames accepted from the receiver:
//     write : CMD_WR, addr, data  -> one rf_wr_en strobe
//     read  : CMD_RD, addr        -> one rf_rd_en strobe, then the read byte
//                                    is sent back through the transmitter
//
//   Ports
//     clk       system clock
//     rst       asynchronous reset, active-low
//     rx_data   received byte, valid while rx_valid=1
//     rx_valid  one-cycle pulse per error-free received byte
//     tx_busy   transmitter busy; a byte is launched only while 0
//     tx_data   byte to transmit (stable while tx_valid=1)
//     tx_valid  one-cycle transmit strobe
//     rf_addr   register address (addr byte LSBs; held until next addr byte)
//     rf_wdata  register write data
//     rf_wr_en  one-cycle write strobe
//     rf_rd_en  one-cycle read strobe
//     rf_rdata  register read data, valid the cycle after rf_rd_en
//     cmd_err   one-cycle pulse: bad opcode, dropped byte or timeout
//
//   Build option: define CMD_TIMEOUT_EN to abandon a partial command after
//   TIMEOUT_CYC idle cycles. Without it a partial command waits forever.
//
//   Every output is a register; the FSM computes next values combinationally.

module uart_sys_ctrl #(
  parameter int unsigned         DATA_W      = 8,
  parameter int unsigned         ADDR_W      = 4,
  parameter logic [DATA_W-1:0]   CMD_WR      = 8'hAA,
  parameter logic [DATA_W-1:0]   CMD_RD      = 8'hBB,
  parameter logic [15:0]         TIMEOUT_CYC = 16'd4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              cmd_err
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] tx_data_nxt;
  logic              tx_valid_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              wr_en_nxt;
  logic              rd_en_nxt;
  logic              err_nxt;
  logic              to_hit;

`ifdef CMD_TIMEOUT_EN
  // Inter-byte watchdog: runs only while a command is partially received.
  logic [15:0] to_cnt;
  logic        counting;

  assign counting = (state == WR_ADDR) || (state == WR_DATA) || (state == RD_ADDR);
  assign to_hit   = counting && (to_cnt == TIMEOUT_CYC - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (rx_valid || !counting || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  logic unused_timeout;

  assign to_hit         = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
      rf_addr  <= addr_nxt;
      rf_wdata <= wdata_nxt;
      rf_wr_en <= wr_en_nxt;
      rf_rd_en <= rd_en_nxt;
      cmd_err  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = 1'b0;
    addr_nxt     = rf_addr;
    wdata_nxt    = rf_wdata;
    wr_en_nxt    = 1'b0;
    rd_en_nxt    = 1'b0;
    err_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WR) begin
            state_nxt = WR_ADDR;
          end else if (rx_data == CMD_RD) begin
            state_nxt = RD_ADDR;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      WR_ADDR: begin
        if (rx_valid) begin
          addr_nxt  = rx_data[ADDR_W-1:0];
          state_nxt = WR_DATA;
        end else if (to_hit) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end

      WR_DATA: begin
        if (rx_valid) begin
          wdata_nxt = rx_data;
          wr_en_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (to_hit) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end

      // RD_ADDR spans the strobe cycle too: the registered rf_rd_en marks it,
      // so RD_WAIT lines up with the cycle the register file presents data.
      // A byte arriving during the strobe cycle belongs to no command.
      RD_ADDR: begin
        if (rf_rd_en) begin
          state_nxt = RD_WAIT;
          err_nxt   = rx_valid;
        end else if (rx_valid) begin
          addr_nxt  = rx_data[ADDR_W-1:0];
          rd_en_nxt = 1'b1;
        end else if (to_hit) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end

      RD_WAIT: begin
        tx_data_nxt = rf_rdata;
        state_nxt   = TX_SEND;
        err_nxt     = rx_valid;
      end

      TX_SEND: begin
        err_nxt = rx_valid;
        if (!tx_busy) begin
          tx_valid_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_sys_ctrl.sv
// tb_uart_sys_ctrl
//   Scoreboard bench for uart_sys_ctrl. Stimulus tasks push the expected
//   register strobes, transmit bytes and error pulses (with the cycle they
//   must appear in); a negedge monitor pops and compares them as the DUT
//   produces them. A small registered register-file model answers reads.

module tb_uart_sys_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [3:0] rf_addr;
  logic [7:0] rf_wdata;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [7:0] rf_rdata;
  logic       cmd_err;

  uart_sys_ctrl #(
    .DATA_W      (8),
    .ADDR_W      (4),
    .CMD_WR      (8'hAA),
    .CMD_RD      (8'hBB),
    .TIMEOUT_CYC (16'd100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .rf_addr  (rf_addr),
    .rf_wdata (rf_wdata),
    .rf_wr_en (rf_wr_en),
    .rf_rd_en (rf_rd_en),
    .rf_rdata (rf_rdata),
    .cmd_err  (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    return (i == 7) ? 8'hA5 : (8'(i * 17) ^ 8'h5A);
  endfunction

  // Register-file model: registered read, junk on cycles without a read so
  // a capture on the wrong cycle shows up.
  logic [7:0] rf_mem [16];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= init_val(i);
      rf_rdata <= 8'h3C;
    end else begin
      if (rf_wr_en) rf_mem[rf_addr] <= rf_wdata;
      rf_rdata <= rf_rd_en ? rf_mem[rf_addr] : 8'h3C;
    end
  end

  typedef struct {
    logic [3:0]  a;
    logic [7:0]  d;
    int unsigned c;
  } ev_t;

  ev_t         exp_wr [$];
  ev_t         exp_rd [$];
  ev_t         exp_tx [$];
  int unsigned exp_err [$];
  logic [7:0]  ref_mem [16];
  ev_t         ev;
  int unsigned ec;

  always @(negedge clk) begin
    if (rst) begin
      if (rf_wr_en || rf_rd_en) check("wr_rd_excl", 32'(rf_wr_en & rf_rd_en), 32'd0);
      if (rf_wr_en) begin
        if (exp_wr.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else begin
          ev = exp_wr.pop_front();
          check("wr_addr", 32'(rf_addr), 32'(ev.a));
          check("wr_data", 32'(rf_wdata), 32'(ev.d));
          check("wr_cycle", cyc, ev.c);
        end
      end
      if (rf_rd_en) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else begin
          ev = exp_rd.pop_front();
          check("rd_addr", 32'(rf_addr), 32'(ev.a));
          check("rd_cycle", cyc, ev.c);
        end
      end
      if (tx_valid) begin
        if (exp_tx.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
        else begin
          ev = exp_tx.pop_front();
          check("tx_data", 32'(tx_data), 32'(ev.d));
          check("tx_cycle", cyc, ev.c);
        end
      end
      if (cmd_err) begin
        if (exp_err.size() == 0) check("err_unexpected", 32'd1, 32'd0);
        else begin
          ec = exp_err.pop_front();
          check("err_cycle", cyc, ec);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int unsigned k);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    k        = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    int unsigned k;
    send_byte(8'hAA, k);
    send_byte(a, k);
    send_byte(d, k);
    exp_wr.push_back('{a: a[3:0], d: d, c: k + 1});
    ref_mem[a[3:0]] = d;
  endtask

  task automatic send_bad(input logic [7:0] b);
    int unsigned k;
    send_byte(b, k);
    exp_err.push_back(k + 1);
  endtask

  // busy: cycles after the address byte during which tx_busy stays high.
  // extra_at: cycle offset (>=2) of a stray byte during the response, 0 = none.
  task automatic do_read(input logic [7:0] a, input int unsigned busy, input int unsigned extra_at);
    int unsigned k;
    int unsigned free_cyc;
    send_byte(8'hBB, k);
    tx_busy = (busy != 0);
    @(posedge clk); #1;
    rx_data  = a;
    rx_valid = 1'b1;
    k        = cyc;
    free_cyc = (busy > 3) ? k + busy : k + 3;
    exp_rd.push_back('{a: a[3:0], d: 8'h00, c: k + 1});
    exp_tx.push_back('{a: a[3:0], d: ref_mem[a[3:0]], c: free_cyc + 1});
    for (int unsigned i = 1; i <= busy + 6; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
      if (i == extra_at) begin
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        exp_err.push_back(k + i + 1);
      end
      if (i == busy) tx_busy = 1'b0;
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    int unsigned k;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    rst      = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_busy  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({tx_data, tx_valid, rf_addr, rf_wdata, rf_wr_en, rf_rd_en, cmd_err}), 32'd0);
    rst = 1'b1;

    // Reset in the middle of a write: command is abandoned.
    send_byte(8'hAA, k);
    send_byte(8'h03, k);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("midcmd_reset_outputs",
          32'({tx_data, tx_valid, rf_addr, rf_wdata, rf_wr_en, rf_rd_en, cmd_err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    // Back in IDLE, so the would-be data byte is an unknown opcode.
    send_bad(8'h5C);
    do_write(8'h03, 8'h5C);

    do_read(8'h03, 0, 0);
    do_read(8'h07, 0, 0);
    do_read(8'h17, 50, 10);   // addr MSBs ignored, long busy, stray byte
    send_bad(8'h12);
    do_write(8'h01, 8'hFF);
    do_read(8'h01, 0, 0);
    do_write(8'hF2, 8'h9A);
    do_read(8'h02, 0, 2);     // stray byte in RD_WAIT
    do_read(8'h0E, 0, 3);     // stray byte collides with the tx launch
    do_write(8'hFE, 8'h00);
    do_read(8'h2E, 5, 0);

`ifdef CMD_TIMEOUT_EN
    send_byte(8'hAA, k);
    exp_err.push_back(k + 101);
    repeat (120) @(posedge clk);
    do_write(8'h01, 8'h11);
`else
    send_byte(8'hAA, k);
    repeat (150) @(posedge clk);
    send_byte(8'h01, k);
    send_byte(8'h11, k);
    exp_wr.push_back('{a: 4'h1, d: 8'h11, c: k + 1});
    ref_mem[1] = 8'h11;
`endif
    do_read(8'h01, 0, 0);

    repeat (10) @(posedge clk);
    check("wr_left", 32'(exp_wr.size()), 32'd0);
    check("rd_left", 32'(exp_rd.size()), 32'd0);
    check("tx_left", 32'(exp_tx.size()), 32'd0);
    check("err_left", 32'(exp_err.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
